riscv_mem: RTL and testbench
============================

RISCV_MEM -- requirements
Module: riscv_mem

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 4096: number of 32-bit words; power of two, 16..65536.
REQ-002 SHALL have parameter READ_LATENCY, default 1: cycles from accepted read request to valid data; legal values 1..4.
REQ-003 SHALL have port clk_in, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_in, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port imem_req_in, input, 1 bit: instruction read request.
REQ-006 SHALL have port imem_addr_in, input, 32 bits: instruction byte address.
REQ-007 SHALL have port imem_data_out, output, 32 bits: instruction read data.
REQ-008 SHALL have port imem_valid_out, output, 1 bit: imem_data_out valid this cycle.
REQ-009 SHALL have port dmem_req_in, input, 1 bit: data request, read or write.
REQ-010 SHALL have port dmem_addr_in, input, 32 bits: data byte address.
REQ-011 SHALL have port dmem_data_in, input, 32 bits: store data, lane-aligned.
REQ-012 SHALL have port dmem_write_enable_in, input, 4 bits: byte-lane write enables; 0 with dmem_req_in means read.
REQ-013 SHALL have port dmem_data_out, output, 32 bits: load data, full word.
REQ-014 SHALL have port dmem_valid_out, output, 1 bit: dmem_data_out valid this cycle.
REQ-015 SHALL have port fault_out, output, 1 bit: misaligned-access fault pulse (see Configuration).

Function
REQ-016 Every request SHALL be accepted in the cycle it is presented; no backpressure; one new request per port per cycle.
REQ-017 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo 4*DEPTH_WORDS.
REQ-018 Read data SHALL appear, with the matching valid asserted for exactly one cycle, READ_LATENCY cycles after acceptance.
REQ-019 Back-to-back reads SHALL be fully pipelined: N consecutive requests yield N consecutive valid cycles in request order.
REQ-020 Data outputs SHALL hold their last valid value while valid is low.
REQ-021 A write SHALL update only lanes with write_enable bit set, at the accepting edge; writes SHALL NOT assert dmem_valid_out.
REQ-022 Read of a word written in the same cycle, on either port, SHALL return the pre-write contents (read-before-write).
REQ-023 A read issued the cycle after a write to the same word SHALL return the new contents.
REQ-024 Memory contents SHALL NOT be cleared by reset; simulation initial contents SHALL be zero.

Reset
REQ-025 While rst_in is high: imem_valid_out=0, dmem_valid_out=0, fault_out=0, imem_data_out=0, dmem_data_out=0, all latency-pipeline valid bits cleared.
REQ-026 Reads in flight when rst_in asserts SHALL be discarded and never produce valid; writes already accepted SHALL persist.
REQ-027 Requests presented while rst_in is high SHALL be ignored, including writes.

Configuration
REQ-028 Macro RISCV_MEM_MISALIGN_TRAP_EN SHALL control misalignment checking.
REQ-029 With the macro defined: a dmem write whose enables are not 0001/0010/0100/1000/0011/1100/1111, an imem request with addr[1:0]!=0, or a dmem read with addr[1:0]!=0 SHALL be suppressed (no write, no valid) and fault_out SHALL pulse high one cycle after acceptance.
REQ-030 Without the macro: addr[1:0] ignored, any enable pattern written as given, fault_out tied 0.

Verification
REQ-031 READ_LATENCY=1: write 32'hDEADBEEF to 0x40 (enables 1111), then imem read 0x40 -> imem_valid_out one cycle later with 32'hDEADBEEF.
REQ-032 Word 0x10 = 32'h00000000; sb-style write 0xAB with enables 0100 at 0x12, then dmem read 0x10 -> 32'h00AB0000.
REQ-033 READ_LATENCY=3: four consecutive dmem reads of 0x0,0x4,0x8,0xC -> valid high cycles 3..6 after first request, data in order.
REQ-034 Same cycle: dmem write 32'h12345678 to 0x80 and imem read 0x80 (old 0) -> imem returns 0; repeat read next cycle -> 32'h12345678.
REQ-035 DEPTH_WORDS=16: write 32'hCAFEF00D to 0x44, read 0x04 -> 32'hCAFEF00D (wrap).
REQ-036 READ_LATENCY=2, macro defined: read request then rst_in high 1 cycle -> no valid ever; imem read 0x2 -> fault_out pulse, no imem_valid_out.

Source files
------------

// File: rtl/riscv_mem.sv
// Dual-port instruction/data memory with a configurable read pipeline and byte-lane writes.
// Define RISCV_MEM_MISALIGN_TRAP_EN to suppress misaligned accesses and report them on fault_out.
module riscv_mem #(
  parameter int DEPTH_WORDS  = 4096,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        imem_req_in,
  input  logic [31:0] imem_addr_in,
  output logic [31:0] imem_data_out,
  output logic        imem_valid_out,
  input  logic        dmem_req_in,
  input  logic [31:0] dmem_addr_in,
  input  logic [31:0] dmem_data_in,
  input  logic [3:0]  dmem_write_enable_in,
  output logic [31:0] dmem_data_out,
  output logic        dmem_valid_out,
  output logic        fault_out
);
  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] i_idx;
  logic [AW-1:0] d_idx;
  logic          i_ok;
  logic          d_ok;
  logic          i_take;
  logic          d_read;
  logic          d_write;
  logic          i_vld [READ_LATENCY];
  logic          d_vld [READ_LATENCY];
  logic [31:0]   i_pipe [READ_LATENCY];
  logic [31:0]   d_pipe [READ_LATENCY];
  logic          unused_addr;

  assign i_idx = imem_addr_in[AW+1:2];
  assign d_idx = dmem_addr_in[AW+1:2];
  assign unused_addr = ^{imem_addr_in[31:AW+2], imem_addr_in[1:0],
                         dmem_addr_in[31:AW+2], dmem_addr_in[1:0]};

`ifdef RISCV_MEM_MISALIGN_TRAP_EN
  // Only naturally shaped byte/half/word stores and word-aligned reads are legal.
  always_comb begin
    i_ok = (imem_addr_in[1:0] == 2'b00);
    d_ok = 1'b0;
    if (dmem_write_enable_in == 4'b0000) begin
      d_ok = (dmem_addr_in[1:0] == 2'b00);
    end else begin
      case (dmem_write_enable_in)
        4'b0001, 4'b0010, 4'b0100, 4'b1000,
        4'b0011, 4'b1100, 4'b1111: d_ok = 1'b1;
        default:                   d_ok = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      fault_out <= 1'b0;
    end else begin
      fault_out <= (imem_req_in & ~i_ok) | (dmem_req_in & ~d_ok);
    end
  end
`else
  assign i_ok      = 1'b1;
  assign d_ok      = 1'b1;
  assign fault_out = 1'b0;
`endif

  assign i_take  = imem_req_in & i_ok;
  assign d_read  = dmem_req_in & d_ok & (dmem_write_enable_in == 4'b0000);
  assign d_write = dmem_req_in & d_ok & (dmem_write_enable_in != 4'b0000) & ~rst_in;

  // Storage is never reset; writes land at the accepting edge, after the same-edge reads sample.
  always_ff @(posedge clk_in) begin
    if (d_write) begin
      for (int b = 0; b < 4; b++) begin
        if (dmem_write_enable_in[b]) begin
          mem[d_idx][8*b +: 8] <= dmem_data_in[8*b +: 8];
        end
      end
    end
  end

  // Data stages only advance behind a valid, so the last stage holds the most recent read.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int s = 0; s < READ_LATENCY; s++) begin
        i_vld[s]  <= 1'b0;
        d_vld[s]  <= 1'b0;
        i_pipe[s] <= '0;
        d_pipe[s] <= '0;
      end
    end else begin
      i_vld[0] <= i_take;
      d_vld[0] <= d_read;
      if (i_take) begin
        i_pipe[0] <= mem[i_idx];
      end
      if (d_read) begin
        d_pipe[0] <= mem[d_idx];
      end
      for (int s = 1; s < READ_LATENCY; s++) begin
        i_vld[s] <= i_vld[s-1];
        d_vld[s] <= d_vld[s-1];
        if (i_vld[s-1]) begin
          i_pipe[s] <= i_pipe[s-1];
        end
        if (d_vld[s-1]) begin
          d_pipe[s] <= d_pipe[s-1];
        end
      end
    end
  end

  assign imem_valid_out = i_vld[READ_LATENCY-1];
  assign imem_data_out  = i_pipe[READ_LATENCY-1];
  assign dmem_valid_out = d_vld[READ_LATENCY-1];
  assign dmem_data_out  = d_pipe[READ_LATENCY-1];

endmodule

// File: tb/tb_riscv_mem.sv
// Self-checking bench for riscv_mem: a small 16-word, 3-cycle-latency instance compared
// cycle by cycle against a queue-based model; honours RISCV_MEM_MISALIGN_TRAP_EN when defined.
module tb_riscv_mem;
  localparam int DEPTH = 16;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req = 1'b0;
  logic [31:0] imem_addr = '0;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        dmem_req = 1'b0;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_wdata = '0;
  logic [3:0]  dmem_we = '0;
  logic [31:0] dmem_rdata;
  logic        dmem_valid;
  logic        fault;

  always #5 clk = ~clk;

  riscv_mem #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(LAT)) dut (
    .clk_in(clk), .rst_in(rst),
    .imem_req_in(imem_req), .imem_addr_in(imem_addr),
    .imem_data_out(imem_rdata), .imem_valid_out(imem_valid),
    .dmem_req_in(dmem_req), .dmem_addr_in(dmem_addr), .dmem_data_in(dmem_wdata),
    .dmem_write_enable_in(dmem_we), .dmem_data_out(dmem_rdata),
    .dmem_valid_out(dmem_valid), .fault_out(fault)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] model_mem [DEPTH];
  rd_t         iq[$];
  rd_t         dq[$];
  logic        exp_iv = 1'b0;
  logic        exp_dv = 1'b0;
  logic        exp_fault = 1'b0;
  logic [31:0] exp_id = '0;
  logic [31:0] exp_dd = '0;
  logic [31:0] last_i = '0;
  logic [31:0] last_d = '0;

  function automatic int widx(logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic logic addr_ok(logic [31:0] a);
`ifdef RISCV_MEM_MISALIGN_TRAP_EN
    return (a % 4) == 0;
`else
    return (a % 4) < 4;
`endif
  endfunction

  function automatic logic we_ok(logic [3:0] w);
`ifdef RISCV_MEM_MISALIGN_TRAP_EN
    return w inside {4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd12, 4'd15};
`else
    return w != 4'd0;
`endif
  endfunction

  task automatic idle();
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 4'b0000;
  endtask

  // Advance one clock and update the reference model from the inputs sampled at that edge.
  task automatic tick();
    rd_t  e;
    logic ok_i;
    logic ok_d;
    @(posedge clk);
    cyc++;
    exp_fault = 1'b0;
    if (rst) begin
      iq.delete();
      dq.delete();
      last_i = '0;
      last_d = '0;
    end else begin
      ok_i = addr_ok(imem_addr);
      ok_d = (dmem_we == 4'b0000) ? addr_ok(dmem_addr) : we_ok(dmem_we);
      exp_fault = (imem_req && !ok_i) || (dmem_req && !ok_d);
      if (imem_req && ok_i) begin
        e.due = cyc + LAT - 1;
        e.data = model_mem[widx(imem_addr)];
        iq.push_back(e);
      end
      if (dmem_req && ok_d && dmem_we == 4'b0000) begin
        e.due = cyc + LAT - 1;
        e.data = model_mem[widx(dmem_addr)];
        dq.push_back(e);
      end
      if (dmem_req && ok_d && dmem_we != 4'b0000) begin
        for (int b = 0; b < 4; b++) begin
          if (dmem_we[b]) model_mem[widx(dmem_addr)][8*b +: 8] = dmem_wdata[8*b +: 8];
        end
      end
    end
    exp_iv = 1'b0;
    if (iq.size() > 0 && iq[0].due == cyc) begin
      e = iq.pop_front();
      last_i = e.data;
      exp_iv = 1'b1;
    end
    exp_dv = 1'b0;
    if (dq.size() > 0 && dq[0].due == cyc) begin
      e = dq.pop_front();
      last_d = e.data;
      exp_dv = 1'b1;
    end
    exp_id = last_i;
    exp_dd = last_d;
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] got = '1;
    logic        seen = 1'b0;
    #2 rst = 1'b1;
    imem_req = 1'b1; imem_addr = 32'h14;
    dmem_req = 1'b1; dmem_addr = 32'h14; dmem_wdata = 32'h55555555; dmem_we = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      tick();
      total += 3;
      if (imem_valid !== 1'b0 || imem_rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_imem got v=%b d=%h want v=0 d=0", imem_valid, imem_rdata); end
      if (dmem_valid !== 1'b0 || dmem_rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_dmem got v=%b d=%h want v=0 d=0", dmem_valid, dmem_rdata); end
      if (fault !== 1'b0) begin bad++; $display("[TB] FAIL reset_fault got %b want 0", fault); end
    end
    rst = 1'b0;
    idle();
    dmem_req = 1'b1; dmem_addr = 32'h14;
    for (int k = 0; k < LAT + 1; k++) begin
      tick();
      if (dmem_valid === 1'b1) begin seen = 1'b1; got = dmem_rdata; end
      idle();
    end
    total++;
    if (!seen || got !== 32'h0) begin bad++; $display("[TB] FAIL reset_write_ignored got seen=%b d=%h want seen=1 d=00000000", seen, got); end
  endtask

  task automatic test_write_read();
    logic [31:0] got = '0;
    logic        seen = 1'b0;
    idle();
    dmem_req = 1'b1; dmem_addr = 32'h40; dmem_wdata = 32'hDEADBEEF; dmem_we = 4'b1111;
    tick();
    idle();
    imem_req = 1'b1; imem_addr = 32'h40;
    for (int k = 0; k < LAT + 1; k++) begin
      tick();
      idle();
      total += 2;
      if (imem_valid !== exp_iv || imem_rdata !== exp_id) begin bad++; $display("[TB] FAIL write_read_imem cyc=%0d got v=%b d=%h want v=%b d=%h", cyc, imem_valid, imem_rdata, exp_iv, exp_id); end
      if (dmem_valid !== exp_dv) begin bad++; $display("[TB] FAIL write_read_no_dvalid got %b want %b", dmem_valid, exp_dv); end
      if (imem_valid === 1'b1) begin seen = 1'b1; got = imem_rdata; end
    end
    total++;
    if (!seen || got !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL write_read_value got seen=%b d=%h want seen=1 d=deadbeef", seen, got); end
  endtask

  task automatic test_byte_lane();
    logic [31:0] got = '0;
    logic        seen = 1'b0;
    idle();
    dmem_req = 1'b1; dmem_addr = 32'h10; dmem_wdata = 32'h0; dmem_we = 4'b1111;
    tick();
    dmem_addr = 32'h12; dmem_wdata = 32'h00AB0000; dmem_we = 4'b0100;
    tick();
    dmem_addr = 32'h10; dmem_we = 4'b0000;
    for (int k = 0; k < LAT + 1; k++) begin
      tick();
      idle();
      total++;
      if (dmem_valid !== exp_dv || dmem_rdata !== exp_dd) begin bad++; $display("[TB] FAIL byte_lane_dmem cyc=%0d got v=%b d=%h want v=%b d=%h", cyc, dmem_valid, dmem_rdata, exp_dv, exp_dd); end
      if (dmem_valid === 1'b1) begin seen = 1'b1; got = dmem_rdata; end
    end
    total++;
    if (!seen || got !== 32'h00AB0000) begin bad++; $display("[TB] FAIL byte_lane_value got seen=%b d=%h want seen=1 d=00ab0000", seen, got); end
  endtask

  task automatic test_back_to_back();
    int first = 0;
    int n_valid = 0;
    idle();
    for (int k = 0; k < 4; k++) begin
      dmem_req = 1'b1; dmem_addr = 32'(4 * k); dmem_wdata = 32'hA0000000 + 32'(k); dmem_we = 4'b1111;
      tick();
    end
    for (int k = 0; k < 4 + LAT + 1; k++) begin
      if (k < 4) begin dmem_req = 1'b1; dmem_addr = 32'(4 * k); dmem_we = 4'b0000; end
      else idle();
      if (k == 0) first = cyc + 1;
      tick();
      total++;
      if (dmem_valid !== exp_dv || dmem_rdata !== exp_dd) begin bad++; $display("[TB] FAIL b2b_dmem cyc=%0d got v=%b d=%h want v=%b d=%h", cyc, dmem_valid, dmem_rdata, exp_dv, exp_dd); end
      if (dmem_valid === 1'b1) begin
        total++;
        if (cyc - first !== LAT - 1 + n_valid || dmem_rdata !== 32'hA0000000 + 32'(n_valid)) begin
          bad++; $display("[TB] FAIL b2b_order got offset=%0d d=%h want offset=%0d d=%h", cyc - first, dmem_rdata, LAT - 1 + n_valid, 32'hA0000000 + 32'(n_valid));
        end
        n_valid++;
      end
    end
    total++;
    if (n_valid !== 4) begin bad++; $display("[TB] FAIL b2b_count got %0d want 4", n_valid); end
  endtask

  task automatic test_read_before_write();
    logic [31:0] got [$];
    idle();
    dmem_req = 1'b1; dmem_addr = 32'h80; dmem_wdata = 32'h12345678; dmem_we = 4'b1111;
    imem_req = 1'b1; imem_addr = 32'h80;
    tick();
    dmem_req = 1'b0; dmem_we = 4'b0000;
    for (int k = 0; k < LAT + 2; k++) begin
      tick();
      idle();
      total++;
      if (imem_valid !== exp_iv || imem_rdata !== exp_id) begin bad++; $display("[TB] FAIL rbw_imem cyc=%0d got v=%b d=%h want v=%b d=%h", cyc, imem_valid, imem_rdata, exp_iv, exp_id); end
      if (imem_valid === 1'b1) got.push_back(imem_rdata);
    end
    total++;
    if (got.size() != 2 || got[1] !== 32'h12345678 || got[0] === 32'h12345678) begin
      bad++; $display("[TB] FAIL rbw_values got n=%0d want 2 reads, old then 12345678", got.size());
    end
  endtask

  task automatic test_wrap();
    logic [31:0] got = '0;
    logic        seen = 1'b0;
    idle();
    dmem_req = 1'b1; dmem_addr = 32'h44; dmem_wdata = 32'hCAFEF00D; dmem_we = 4'b1111;
    tick();
    dmem_addr = 32'h04; dmem_we = 4'b0000;
    for (int k = 0; k < LAT + 1; k++) begin
      tick();
      idle();
      if (dmem_valid === 1'b1) begin seen = 1'b1; got = dmem_rdata; end
    end
    total++;
    if (!seen || got !== 32'hCAFEF00D) begin bad++; $display("[TB] FAIL wrap_value got seen=%b d=%h want seen=1 d=cafef00d", seen, got); end
  endtask

  task automatic test_reset_inflight();
    logic seen = 1'b0;
    idle();
    dmem_req = 1'b1; dmem_addr = 32'h0;
    imem_req = 1'b1; imem_addr = 32'h4;
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      tick();
      total += 2;
      if (imem_valid !== exp_iv || imem_rdata !== exp_id) begin bad++; $display("[TB] FAIL inflight_imem cyc=%0d got v=%b d=%h want v=%b d=%h", cyc, imem_valid, imem_rdata, exp_iv, exp_id); end
      if (dmem_valid !== exp_dv || dmem_rdata !== exp_dd) begin bad++; $display("[TB] FAIL inflight_dmem cyc=%0d got v=%b d=%h want v=%b d=%h", cyc, dmem_valid, dmem_rdata, exp_dv, exp_dd); end
      if (imem_valid === 1'b1 || dmem_valid === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("[TB] FAIL inflight_discard got valid=%b want 0", seen); end
  endtask

  task automatic test_misalign();
    logic fault_seen = 1'b0;
    logic valid_seen = 1'b0;
    idle();
    imem_req = 1'b1; imem_addr = 32'h2;
    tick();
    idle();
    dmem_req = 1'b1; dmem_addr = 32'h8; dmem_wdata = 32'h11111111; dmem_we = 4'b0101;
    for (int k = 0; k < LAT + 2; k++) begin
      tick();
      if (k == 0) begin dmem_addr = 32'h9; dmem_we = 4'b0000; end
      else idle();
      total += 3;
      if (fault !== exp_fault) begin bad++; $display("[TB] FAIL misalign_fault cyc=%0d got %b want %b", cyc, fault, exp_fault); end
      if (imem_valid !== exp_iv || imem_rdata !== exp_id) begin bad++; $display("[TB] FAIL misalign_imem cyc=%0d got v=%b d=%h want v=%b d=%h", cyc, imem_valid, imem_rdata, exp_iv, exp_id); end
      if (dmem_valid !== exp_dv || dmem_rdata !== exp_dd) begin bad++; $display("[TB] FAIL misalign_dmem cyc=%0d got v=%b d=%h want v=%b d=%h", cyc, dmem_valid, dmem_rdata, exp_dv, exp_dd); end
      if (fault === 1'b1) fault_seen = 1'b1;
      if (imem_valid === 1'b1) valid_seen = 1'b1;
    end
    total++;
`ifdef RISCV_MEM_MISALIGN_TRAP_EN
    if (fault_seen !== 1'b1 || valid_seen !== 1'b0) begin bad++; $display("[TB] FAIL misalign_summary got fault=%b ivalid=%b want fault=1 ivalid=0", fault_seen, valid_seen); end
`else
    if (fault_seen !== 1'b0 || valid_seen !== 1'b1) begin bad++; $display("[TB] FAIL misalign_summary got fault=%b ivalid=%b want fault=0 ivalid=1", fault_seen, valid_seen); end
`endif
  endtask

  task automatic test_random();
    for (int k = 0; k < 250; k++) begin
      imem_req = ($urandom_range(0, 1) == 1);
      imem_addr = $urandom();
      if ($urandom_range(0, 3) != 0) imem_addr[1:0] = 2'b00;
      dmem_req = ($urandom_range(0, 2) != 0);
      dmem_addr = $urandom();
      if ($urandom_range(0, 3) != 0) dmem_addr[1:0] = 2'b00;
      dmem_wdata = $urandom();
      dmem_we = ($urandom_range(0, 1) == 1) ? 4'(($urandom_range(0, 15))) : 4'b0000;
      tick();
      total += 3;
      if (imem_valid !== exp_iv || imem_rdata !== exp_id) begin bad++; $display("[TB] FAIL random_imem cyc=%0d got v=%b d=%h want v=%b d=%h", cyc, imem_valid, imem_rdata, exp_iv, exp_id); end
      if (dmem_valid !== exp_dv || dmem_rdata !== exp_dd) begin bad++; $display("[TB] FAIL random_dmem cyc=%0d got v=%b d=%h want v=%b d=%h", cyc, dmem_valid, dmem_rdata, exp_dv, exp_dd); end
      if (fault !== exp_fault) begin bad++; $display("[TB] FAIL random_fault cyc=%0d got %b want %b", cyc, fault, exp_fault); end
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    test_reset();
    test_write_read();
    test_byte_lane();
    test_back_to_back();
    test_read_before_write();
    test_wrap();
    test_reset_inflight();
    test_misalign();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
